// File: rtl/rom_load_pkg.sv
// rtl/rom_load_pkg.sv - shared types and limits for the ROM download sequencer
package rom_load_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam int MAX_NREG = 8;
  localparam int DL_AW    = 25;

endpackage

// File: rtl/rld_hold_timer.sv
// rtl/rld_hold_timer.sv - loadable down-counter timing the post-load core reset hold
module rld_hold_timer #(
  parameter int RST_HOLD = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(RST_HOLD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Done is raised during the last enabled cycle so the caller leaves on that edge.
  assign done = en && (cnt == '0);

endmodule

// File: rtl/rom_load_seq.sv
// rtl/rom_load_seq.sv - steers HPS ROM download bytes into region strobes and gates core reset
module rom_load_seq
  import rom_load_pkg::*;
#(
  parameter int NREG      = 4,
  parameter int REG_SHIFT = 14,
  parameter int EXP_BYTES = 65536,
  parameter int RST_HOLD  = 256
) (
  input  logic                 CLK24M,
  input  logic                 RESET,
  input  logic                 DL,
  input  logic                 DL_WR,
  input  logic [DL_AW-1:0]     DL_ADDR,
  input  logic [7:0]           DL_DATA,
  output logic [NREG-1:0]      ROM_WE,
  output logic [REG_SHIFT-1:0] ROM_AD,
  output logic [7:0]           ROM_DT,
  output logic                 CORE_RST,
  output logic                 LOADED,
  output logic                 ERR,
  output logic [7:0]           CSUM
);

  localparam int RW = DL_AW - REG_SHIFT;
  localparam logic [DL_AW-1:0] CNT_MAX = '1;
  localparam logic [DL_AW-1:0] CNT_EXP = DL_AW'(EXP_BYTES);

  if (NREG < 1 || NREG > MAX_NREG) begin : g_bad_nreg
    $error("rom_load_seq: NREG out of range");
  end

  state_t           state;
  state_t           state_nxt;
  logic [DL_AW-1:0] byte_cnt;
  logic [DL_AW-1:0] cnt_nxt;
  logic             bad_addr;
  logic             bad_nxt;
  logic [RW-1:0]    region;
  logic             in_range;
  logic             wr_good;
  logic             wr_bad;
  logic             load_ok;
  logic             enter_load;
  logic             hold_load;
  logic             hold_done;

  // Whole upper address decides the region so far-out addresses never alias into a bank.
  assign region   = DL_ADDR[DL_AW-1:REG_SHIFT];
  assign in_range = 32'(region) < 32'(NREG);
  assign wr_good  = (state == LOAD) && DL_WR && in_range;
  assign wr_bad   = (state == LOAD) && DL_WR && !in_range;

  // The write landing in the cycle DL drops must count towards the size verdict.
  assign cnt_nxt  = (wr_good && (byte_cnt != CNT_MAX)) ? byte_cnt + DL_AW'(1) : byte_cnt;
  assign bad_nxt  = bad_addr || wr_bad;
  assign load_ok  = (cnt_nxt == CNT_EXP) && !bad_nxt;

  always_comb begin
    state_nxt = state;
    hold_load = 1'b0;
    case (state)
      BOOT: begin
        if (DL) state_nxt = LOAD;
      end
      LOAD: begin
        if (!DL) begin
          if (load_ok) begin
            state_nxt = HOLD;
            hold_load = 1'b1;
          end else begin
            state_nxt = BOOT;
          end
        end
      end
      HOLD: begin
        if (DL)             state_nxt = LOAD;
        else if (hold_done) state_nxt = RUN;
      end
      RUN: begin
        if (DL) state_nxt = LOAD;
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign enter_load = (state_nxt == LOAD) && (state != LOAD);

  rld_hold_timer #(
    .RST_HOLD (RST_HOLD)
  ) u_hold_timer (
    .clk  (CLK24M),
    .rst  (RESET),
    .load (hold_load),
    .en   (state == HOLD),
    .done (hold_done)
  );

  always_ff @(posedge CLK24M or posedge RESET) begin
    if (RESET) begin
      state    <= BOOT;
      byte_cnt <= '0;
      bad_addr <= 1'b0;
      ROM_WE   <= '0;
      ROM_AD   <= '0;
      ROM_DT   <= '0;
      CORE_RST <= 1'b1;
      LOADED   <= 1'b0;
      ERR      <= 1'b0;
      CSUM     <= '0;
    end else begin
      state  <= state_nxt;
      ROM_WE <= wr_good ? (NREG'(1) << region) : '0;
      if (wr_good) begin
        ROM_AD <= DL_ADDR[REG_SHIFT-1:0];
        ROM_DT <= DL_DATA;
      end
      if (enter_load) begin
        byte_cnt <= '0;
        bad_addr <= 1'b0;
        ERR      <= 1'b0;
        CSUM     <= '0;
      end else if (state == LOAD) begin
        byte_cnt <= cnt_nxt;
        bad_addr <= bad_nxt;
        if (wr_good)            CSUM <= CSUM + DL_DATA;
        if (!DL && !load_ok)    ERR  <= 1'b1;
      end
      // Driven from the next state so reset asserts in the same cycle a reload starts.
      CORE_RST <= (state_nxt != RUN);
      LOADED   <= (state_nxt == RUN);
    end
  end

endmodule
